// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// hardwired-zero entry 0, pending-write scoreboard and post-reset clear engine.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_index,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_index,
    input  logic [NUM_RD*ADDR_W-1:0] rd_index,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_nx;
    logic [DEPTH-1:0]  busy, busy_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              wr_fire;

    assign run     = (state == ST_RUN);
    assign ready   = run;
    assign wr_fire = run && wb_en && (wb_index != '0);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            busy    <= busy_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        busy_nx    = busy;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
                // Write-back clears first so a same-cycle issue (newer producer) wins.
                if (wb_en) busy_nx[wb_index] = 1'b0;
                if (iss_en && (iss_index != '0)) busy_nx[iss_index] = 1'b1;
            end
        endcase
        busy_nx[0] = 1'b0;
    end

    // NOTE: the array has no reset; it is zeroed one entry per cycle by the
    // clear engine, which keeps reset fan-out off the storage flops.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_fire) begin
            mem[wb_index] <= wb_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              fwd;

        assign idx = rd_index[k*ADDR_W +: ADDR_W];
        assign fwd = (BYPASS != 0) && wb_en && (wb_index == idx);

        assign rd_data[k*DATA_W +: DATA_W] = (!run || (idx == '0)) ? '0 :
                                             fwd ? wb_data : mem[idx];
        // A forwarded result is no longer a hazard for the reader.
        assign rd_busy[k] = run && (idx != '0) && !fwd && busy[idx];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: bypass and non-bypass instances share
// stimulus; a behavioural model feeds a scoreboard queue drained by a monitor.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wb_en;
    logic [AW-1:0]    wb_index;
    logic [DW-1:0]    wb_data;
    logic             iss_en;
    logic [AW-1:0]    iss_index;
    logic [NR*AW-1:0] rd_index;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             ready_b, ready_n;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
        .iss_en(iss_en), .iss_index(iss_index), .rd_index(rd_index),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .ready(ready_b)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
        .iss_en(iss_en), .iss_index(iss_index), .rd_index(rd_index),
        .rd_data(rd_data_n), .rd_busy(rd_busy_n), .ready(ready_n)
    );

    typedef struct {
        logic             rdy;
        logic [NR*DW-1:0] data_b;
        logic [NR-1:0]    busy_b;
        logic [NR*DW-1:0] data_n;
        logic [NR-1:0]    busy_n;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: register contents, pending flags, clear cycles left.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    int            m_clear;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_clear = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic bit m_ready();
        return rst && (m_clear == 0);
    endfunction

    function automatic void predict(input bit byp, output logic [NR*DW-1:0] d,
                                    output logic [NR-1:0] b);
        logic [AW-1:0] idx;
        d = '0;
        b = '0;
        for (int k = 0; k < NR; k++) begin
            idx = rd_index[k*AW +: AW];
            if (m_ready() && idx != 0) begin
                if (byp && wb_en && wb_index == idx) begin
                    d[k*DW +: DW] = wb_data;
                end else begin
                    d[k*DW +: DW] = m_mem[idx];
                    b[k]          = m_busy[idx];
                end
            end
        end
    endfunction

    // Queue the expected response for the current inputs, then advance one edge.
    task automatic step(input string name);
        exp_t e;
        if (!rst) model_reset();
        e.rdy = m_ready();
        predict(1'b1, e.data_b, e.busy_b);
        predict(1'b0, e.data_n, e.busy_n);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (m_clear > 0) begin
            m_clear--;
        end else begin
            if (wb_en && wb_index != 0) m_mem[wb_index] = wb_data;
            if (wb_en) m_busy[wb_index] = 1'b0;
            if (iss_en && iss_index != 0) m_busy[iss_index] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wb_en     = 1'b0;
        wb_index  = '0;
        wb_data   = '0;
        iss_en    = 1'b0;
        iss_index = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c, input logic [AW-1:0] d);
        rd_index = {d, c, b, a};
    endtask

    task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        wb_en    = 1'b1;
        wb_index = idx;
        wb_data  = data;
    endtask

    function automatic logic [AW-1:0] rand_idx();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        wb_en     = 1'($urandom_range(0, 1));
        wb_index  = rand_idx();
        wb_data   = $urandom;
        iss_en    = 1'($urandom_range(0, 1));
        iss_index = rand_idx();
        set_rd(rand_idx(), rand_idx(), rand_idx(), rand_idx());
    endtask

    // Monitor: outputs are combinational, so one response per cycle at negedge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".ready_b"}, 128'(ready_b), 128'(e.rdy));
                check({nm, ".ready_n"}, 128'(ready_n), 128'(e.rdy));
                check({nm, ".data_b"}, rd_data_b, e.data_b);
                check({nm, ".busy_b"}, 128'(rd_busy_b), 128'(e.busy_b));
                check({nm, ".data_n"}, rd_data_n, e.data_n);
                check({nm, ".busy_n"}, 128'(rd_busy_n), 128'(e.busy_n));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        idle();
        set_rd(1, 2, 3, 4);
        model_reset();
        @(posedge clk);
        #1;

        // Reset, then clear with ignored traffic.
        repeat (3) step("reset");
        rst = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            rand_inputs();
            step("clear");
        end
        idle();
        for (int i = 1; i < DEPTH; i += NR)
            set_rd_step: begin
                set_rd(AW'((i - 1) % 31 + 1), AW'(i % 31 + 1), AW'((i + 1) % 31 + 1),
                       AW'((i + 2) % 31 + 1));
                step("cleared");
            end

        // Write then read, and dropped write to entry 0.
        wr(5, 32'hDEAD_BEEF);
        set_rd(5, 5, 0, 0);
        step("wr5");
        idle();
        set_rd(5, 5, 5, 5);
        step("rd5");
        wr(0, 32'h0000_1234);
        set_rd(0, 0, 0, 0);
        step("wr0");
        idle();
        step("rd0");

        // Bypass: entry 7 holds 0x77 and is pending, then written while read.
        wr(7, 32'h77);
        iss_en    = 1'b1;
        iss_index = 7;
        step("wr_iss7");
        idle();
        set_rd(0, 7, 7, 0);
        step("pend7");
        wr(7, 32'hA5A5_A5A5);
        step("byp7");
        idle();
        step("byp7_next");

        // Scoreboard: issue, gap, write-back.
        iss_en    = 1'b1;
        iss_index = 9;
        set_rd(9, 9, 9, 9);
        step("iss9");
        idle();
        repeat (3) step("gap9");
        wr(9, $urandom);
        step("wb9");
        idle();
        step("after9");
        wr(9, 32'h9999);
        iss_en    = 1'b1;
        iss_index = 9;
        step("same9");
        idle();
        step("same9_after");
        iss_en    = 1'b1;
        iss_index = 0;
        set_rd(0, 0, 9, 0);
        step("iss0");
        idle();
        step("iss0_after");

        // Multi-port concurrent reads.
        for (int i = 1; i <= 4; i++) begin
            wr(AW'(i), DW'(i * 32'h11));
            step("mp_load");
        end
        idle();
        set_rd(1, 2, 3, 4);
        step("mp");

        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            step("rand");
        end

        // Reset mid-operation.
        idle();
        wr(3, 32'h3333_3333);
        step("pre3");
        wr(4, 32'h4444_4444);
        step("pre4");
        idle();
        iss_en    = 1'b1;
        iss_index = 6;
        step("pre6");
        idle();
        set_rd(6, 3, 4, 6);
        step("pre_rst");
        rst = 1'b0;
        #1;
        check("async_ready", 128'(ready_b), 128'(0));
        check("async_busy", 128'(rd_busy_b), 128'(0));
        repeat (2) step("mid_rst");
        rst = 1'b1;
        repeat (DEPTH) step("reclear");
        set_rd(3, 4, 3, 4);
        step("post_rst");
        for (int c = 0; c < 40; c++) begin
            rand_inputs();
            step("rand2");
        end

        idle();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-config CPU register file, sitting between ID (reads) and WB (writes) of the pipeline.
- Adds configurable width, depth and read-port count, optional write-to-read bypass, hardwired-zero entry 0 and a pending-write scoreboard for hazard detection.
- Storage is cleared after reset by a sequential clear engine rather than a reset fan-out to every flop.
- `ready` tells the pipeline when the clear has finished.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads see array contents only

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_en  in  1  write-back enable
- wb_index  in  ADDR_W  write-back destination index
- wb_data  in  DATA_W  write-back data
- iss_en  in  1  instruction issue; marks iss_index pending
- iss_index  in  ADDR_W  destination of the issuing instruction
- rd_index  in  NUM_RD*ADDR_W  packed read indices; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per-port pending-write flag
- ready  out  1  1 = clear finished, normal operation

Behaviour:
- State machine has two states, CLEAR and RUN.
  - rst low, at any time: asynchronously enter CLEAR, clear counter = 0, all busy bits = 0, ready = 0.
- CLEAR state:
  - Each clk: entry[counter] <= 0 and counter += 1.
  - After entry DEPTH-1 is written, move to RUN at that edge.
  - CLEAR therefore lasts exactly DEPTH cycles after rst rises; ready goes to 1 on the following cycle.
  - Counter width is ADDR_W+1 so it does not wrap.
- While ready = 0:
  - wb_en and iss_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Write, RUN state:
  - If wb_en and wb_index != 0: entry[wb_index] <= wb_data on the rising edge.
  - Writes to index 0 are dropped; entry 0 always reads 0.
- Read (combinational, zero latency), per port k:
  - Index 0 returns 0.
  - Else if BYPASS = 1, wb_en = 1 and wb_index == rd_index[k]: return wb_data.
  - Else return entry[rd_index[k]].
  - Ports are fully independent; identical indices on several ports are legal.
- Scoreboard, one busy bit per entry; busy[0] is constant 0.
  - Edge update order: first clear busy[wb_index] if wb_en; then set busy[iss_index] if iss_en and iss_index != 0.
  - When issue and write-back target the same index in the same cycle, busy ends up 1 (the newer producer wins).
  - Multiple outstanding issues to one index are not counted; the first write-back clears the bit. Avoiding this is the issue logic's responsibility.
- rd_busy[k]:
  - Equals busy[rd_index[k]].
  - Exception: if BYPASS = 1 and the same-cycle write-back matches rd_index[k] (non-zero), rd_busy[k] = 0, because the data is being forwarded.
- Reset values: rd_data = 0, rd_busy = 0, ready = 0; array contents are undefined until CLEAR completes.
- wb_en during CLEAR is lost, not deferred.
- Fully synthesizable. The array carries no reset; only the FSM, counter and busy bits are asynchronously reset.

Test Plan:
- Reset and clear:
  - Stimulus: rst low 3 cycles, then high; ADDR_W = 5.
  - Required: ready = 0 for 32 cycles and 1 on cycle 33; all rd_data = 0 throughout; reading entries 1..31 after ready returns 0.
- Write and read:
  - Stimulus: write 0xDEADBEEF to entry 5, then read port 0 = 5 and port 1 = 5 on the next cycle.
  - Required: both ports return 0xDEADBEEF.
  - Stimulus: write 0x1234 to entry 0.
  - Required: reading entry 0 returns 0.
- Bypass:
  - Stimulus: BYPASS = 1, wb 0xA5A5A5A5 to entry 7 while port 1 reads entry 7 in the same cycle.
  - Required: rd_data port 1 = 0xA5A5A5A5 and rd_busy[1] = 0 that cycle.
  - Same stimulus with BYPASS = 0.
  - Required: old value is returned in that cycle and the new value in the next cycle.
- Scoreboard:
  - Stimulus: iss_en to entry 9; three cycles later wb to entry 9.
  - Required: rd_busy = 1 for reads of entry 9 during the gap and 0 after the write-back edge.
  - Stimulus: iss_en and wb_en both to entry 9 in the same cycle.
  - Required: busy = 1 afterwards.
  - Stimulus: iss_en to entry 0.
  - Required: busy stays 0.
- Reset mid-operation:
  - Stimulus: after writing entries 3 and 4 with busy[6] = 1, drop rst asynchronously between clock edges.
  - Required: ready falls immediately and rd_busy = 0; after release and 32 clear cycles, entries 3 and 4 read 0.
- Multi-port:
  - Stimulus: NUM_RD = 4, distinct indices 1..4 preloaded with 0x11, 0x22, 0x33, 0x44.
  - Required: all four values appear concurrently on their correct packed slices.
